// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered result stage and a sticky
// status register. Logic, add/sub, compare and shift ops complete in one
// cycle; MUL runs a WIDTH-step shift-add sequence while the input stalls.
//
// States:
//   IDLE    | accepting ops; non-MUL results registered on the accepting edge
//   MUL_RUN | shift-add multiply in progress; inputs ignored, busy = 1
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake
//   In1, In2            operands (In2 pre-sign-extended by the caller)
//   aluControl          instruction word; op = [15:12], or [7:4] when [15:12]==0
//   Out, Flags          registered result and per-op flags {Z,C,F,L,N}
//   out_valid           one-cycle pulse per completed op
//   psr                 sticky status {Z,C,F,L,N}
//   busy                multiply in progress
module alu_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [15:0]      aluControl,
  output logic [WIDTH-1:0] Out,
  output logic [4:0]       Flags,
  output logic             out_valid,
  output logic [4:0]       psr,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_LSH  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_NOT  = 4'b1111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [4:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       psr_q, psr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [3:0]         op;
  logic               unused_ctrl_bits;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic [4:0]         alu_flags;
  logic               psr_load;
  logic [WIDTH-1:0]   mul_step;

  assign op = (aluControl[15:12] == 4'b0000) ? aluControl[7:4] : aluControl[15:12];
  assign unused_ctrl_bits = ^{aluControl[11:8], aluControl[3:0]};
  assign shamt = In2[SHAMT_W-1:0];

  // ADDC folds in the carry as it stands before this edge, so an ADDC right
  // behind a flag-setting op naturally sees that op's C.
  assign add_sum  = {1'b0, In1} + {1'b0, In2} +
                    {{WIDTH{1'b0}}, (op == OP_ADDC) & psr_q[3]};
  assign sub_diff = {1'b0, In1} - {1'b0, In2};
  // Carry into the MSB xor carry out of it; stays correct with a carry-in.
  assign add_ovf  = (In1[WIDTH-1] ^ In2[WIDTH-1] ^ add_sum[WIDTH-1]) ^ add_sum[WIDTH];
  assign sub_ovf  = (In1[WIDTH-1] != In2[WIDTH-1]) && (sub_diff[WIDTH-1] != In1[WIDTH-1]);

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    psr_load  = 1'b0;
    case (op)
      OP_AND: alu_res = In1 & In2;
      OP_OR:  alu_res = In1 | In2;
      OP_XOR: alu_res = In1 ^ In2;
      OP_NOT: alu_res = ~In1;
      OP_ADD, OP_ADDC: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_flags = {~|add_sum[WIDTH-1:0], add_sum[WIDTH], add_ovf, 2'b00};
        psr_load  = 1'b1;
      end
      OP_ADDU: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_flags = {~|add_sum[WIDTH-1:0], add_sum[WIDTH], add_sum[WIDTH], 2'b00};
        psr_load  = 1'b1;
      end
      OP_SUB: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_flags = {~|sub_diff[WIDTH-1:0], sub_diff[WIDTH], sub_ovf, 2'b00};
        psr_load  = 1'b1;
      end
      OP_CMP: begin
        alu_flags = {In1 == In2, 1'b0, 1'b0, In1 > In2, $signed(In1) < $signed(In2)};
        psr_load  = 1'b1;
      end
      OP_LSH: alu_res = In2[WIDTH-1] ? (In1 >> shamt) : (In1 << shamt);
      default: alu_res = '0;
    endcase
  end

  assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    psr_d       = psr_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d  = MUL_RUN;
            mcand_d  = In1;
            mplier_d = In2;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            out_d       = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
            if (psr_load) psr_d = alu_flags;
          end
        end
      end
      MUL_RUN: begin
        // Always WIDTH steps, even for a zero operand, so latency is fixed.
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          out_d       = mul_step;
          flags_d     = '0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      psr_q       <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      psr_q       <= psr_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL_RUN);
  assign Out       = out_q;
  assign Flags     = flags_q;
  assign out_valid = out_valid_q;
  assign psr       = psr_q;

endmodule
